// File: rtl/ls_unit.sv
// rtl/ls_unit.sv - load/store sequencer between a CPU request port and a synchronous RAM
//
// Purpose
//   Accepts one load or store burst at a time while idle, range-checks it
//   against the RAM depth, then steps MAR through the burst with one RAM
//   access per word. Loads pass through MDR to rdata; stores take each word
//   through a wvalid/wready handshake into MDR before writing it.
//
// Ports
//   clk, rst                  : clock (rising edge), synchronous active-low reset
//   req, we, addr, len        : request strobe, 1 = store / 0 = load, start address,
//                               word count; all sampled only while idle
//   wdata, wvalid, wready     : store data handshake
//   rdata, rvalid             : MDR contents, one-cycle valid per loaded word
//   busy, done, err           : operation in progress, completion pulse, range error pulse
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata      : synchronous RAM port; read data is valid RD_LAT
//                               cycles after the ram_en cycle
module ls_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int MEM_AW = 4,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_ISSUE,
    DONE
  } state_t;

  // Highest legal RAM word address, held at the widened range-check width.
  localparam logic [ADDR_W:0] MEM_TOP   = (ADDR_W+1)'((1 << MEM_AW) - 1);
  // RD_WAIT counts 0..RD_LAT-1; RD_LAT is at most 4, so two bits suffice.
  localparam logic [1:0]      LAST_WAIT = 2'(RD_LAT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] mar, mar_nx;
  logic [DATA_W-1:0] mdr, mdr_nx;
  logic [LEN_W-1:0]  cnt, cnt_nx;
  logic [1:0]        wait_cnt, wait_cnt_nx;
  logic              range_err, range_err_nx;

  logic [ADDR_W:0]   end_addr;
  logic              bad_range;
  logic              last_word;

  // The end address is formed one bit wider than addr so that a burst
  // running past the top of the CPU address space is still caught rather
  // than wrapping into a small, apparently legal value.
  assign end_addr  = {1'b0, addr} + (ADDR_W+1)'(len) - (ADDR_W+1)'(1);
  assign bad_range = (len == '0) || (end_addr > MEM_TOP);
  assign last_word = (cnt == LEN_W'(1));

  // MDR is architecturally visible: it holds the last loaded (or accepted
  // store) word between rvalid pulses.
  assign rdata     = mdr;
  assign ram_addr  = mar[MEM_AW-1:0];
  assign ram_wdata = mdr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
      range_err <= 1'b0;
    end else begin
      state     <= state_nx;
      mar       <= mar_nx;
      mdr       <= mdr_nx;
      cnt       <= cnt_nx;
      wait_cnt  <= wait_cnt_nx;
      range_err <= range_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    mar_nx       = mar;
    mdr_nx       = mdr;
    cnt_nx       = cnt;
    wait_cnt_nx  = wait_cnt;
    range_err_nx = range_err;
    busy         = (state != IDLE);
    wready       = 1'b0;
    rvalid       = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          mar_nx       = addr;
          cnt_nx       = len;
          range_err_nx = bad_range;
          if (bad_range) begin
            state_nx = DONE;
          end else if (we) begin
            state_nx = WR_WAIT;
          end else begin
            state_nx = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        ram_en      = 1'b1;
        wait_cnt_nx = '0;
        state_nx    = RD_WAIT;
      end

      RD_WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          mdr_nx   = ram_rdata;
          state_nx = RD_RESP;
        end else begin
          wait_cnt_nx = wait_cnt + 2'd1;
        end
      end

      RD_RESP: begin
        rvalid = 1'b1;
        mar_nx = mar + ADDR_W'(1);
        cnt_nx = cnt - LEN_W'(1);
        // Loads finish straight from the last response; done rides with
        // the final rvalid instead of costing an extra DONE cycle.
        if (last_word) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = RD_ISSUE;
        end
      end

      WR_WAIT: begin
        wready = 1'b1;
        if (wvalid) begin
          mdr_nx   = wdata;
          state_nx = WR_ISSUE;
        end
      end

      WR_ISSUE: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        mar_nx   = mar + ADDR_W'(1);
        cnt_nx   = cnt - LEN_W'(1);
        state_nx = last_word ? DONE : WR_WAIT;
      end

      DONE: begin
        done     = 1'b1;
        err      = range_err;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
